prio_encoder_8to3_seq: RTL and testbench
========================================

# prio_encoder_8to3_seq

Sequential 8-to-3 priority encoder and serializer: the inverse of the team's 3-to-8 enable-gated decoder. It captures an 8-bit request vector on a load strobe, then emits the 3-bit index of every set bit, one index per accepted handshake, in priority order. It sits between a multi-source request register and any consumer that services one indexed source at a time, such as a decoder-driven select bus.

## Interface
Parameters:
- HIGH_FIRST, default 1: scan order. 1 = highest index first (bit 7 to bit 0); 0 = lowest index first.

Ports:
- clk  in  1  single clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-high reset
- E  in  1  enable; gates capture only
- D  in  8  request vector
- load  in  1  capture strobe
- ready  in  1  consumer accepts the current index
- A  out  3  encoded index of the current pending bit
- V  out  1  A is valid
- last  out  1  A is the final pending index of the captured word
- busy  out  1  a word is being drained
- Z  out  1  one-cycle pulse: load accepted with D == 0

## Operation
- State register: pend[7:0] and FSM {IDLE, DRAIN}.
- IDLE:
  - load && E && D != 0 → pend <= D, go to DRAIN.
  - load && E && D == 0 → stay in IDLE, pend unchanged, Z = 1 for the next cycle.
  - load && !E → ignored.
- DRAIN:
  - V = 1, busy = 1.
  - A = index of the highest set bit of pend (HIGH_FIRST = 1) or the lowest set bit (HIGH_FIRST = 0).
  - last = 1 when exactly one bit of pend is set.
  - V && ready → clear bit A of pend. If last, go to IDLE.
- load, E and D are ignored throughout DRAIN. There is no queueing; the upstream must wait for busy = 0.
- A, V, last and busy decode combinationally from pend and state only, with no path from D, load or ready. In IDLE, A = 0 and last = 0.
- Z is a registered pulse.
- Reset (any time, including mid-drain): state = IDLE, pend = 0, Z = 0. All outputs go to 0 immediately, without waiting for a clock edge. The next load after rst deasserts behaves normally.

## Timing
- Load accepted at edge n → V = 1 and first A valid in the cycle after edge n (latency 1).
- With ready held at 1, a word with k set bits produces k consecutive valid cycles. busy falls after the edge that accepts the last index.
- Turnaround: a new load is accepted in the first IDLE cycle. Minimum word-to-word gap is 1 cycle with V = 0.
- Backpressure: while V && !ready, A, V and last hold stable.
- ready may be high when V = 0; it has no effect.
- Z is high for exactly the one cycle after the accepting edge.

## Configuration
- PENDING_COUNT_EN defined: adds output port cnt (out, 4 bits), equal to the popcount of pend (0 to 8).
  - cnt is 0 in IDLE and under reset.
  - cnt decrements by 1 on every accepted handshake.
- PENDING_COUNT_EN undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- HIGH_FIRST = 1, load D = 8'b1010_0100 with ready = 1 → A = 7, 5, 2 on three consecutive cycles. last = 1 only with A = 2; busy = 0 on the following cycle. With PENDING_COUNT_EN: cnt = 3, 2, 1, then 0.
- HIGH_FIRST = 0, same D → A = 2, 5, 7.
- Load D = 8'hFF, then drop ready for 3 cycles after the first index → A = 7 and V = 1 hold for those 3 cycles. Indices 7 down to 0 then complete in order.
- load with D = 8'h00 and E = 1 → V stays 0, Z = 1 for exactly one cycle. load with D = 8'h10 and E = 0 → no response.
- Mid-drain of D = 8'h81, assert a load with D = 8'h0F → ignored; the sequence is 7 then 0 only.
- Assert rst asynchronously between edges during a drain → V, A, busy and last are 0 before the next edge. After release, load D = 8'h02 → A = 1 with last = 1.

Source files
------------

// File: rtl/prio_encoder_8to3_seq.sv
// Sequential 8-to-3 priority encoder/serializer: captures a request word, then emits one index per handshake.
// Optional macro PENDING_COUNT_EN adds the cnt output (popcount of pending bits).
module prio_encoder_8to3_seq #(
  parameter int HIGH_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       E,
  input  logic [7:0] D,
  input  logic       load,
  input  logic       ready,
  output logic [2:0] A,
  output logic       V,
  output logic       last,
  output logic       busy,
`ifdef PENDING_COUNT_EN
  output logic [3:0] cnt,
`endif
  output logic       Z
);

  // state   | meaning
  // S_IDLE  | no word held; waiting for load && E
  // S_DRAIN | emitting indices of r_pend, one per accepted handshake
  typedef enum logic {S_IDLE, S_DRAIN} state_t;

  state_t     r_state;
  logic [7:0] r_pend;
  logic       r_z;
  logic [2:0] w_idx;
  logic       w_onehot;
  logic       w_drain;

  // Later loop iterations win, so the scan direction selects the priority.
  always_comb begin
    w_idx = 3'd0;
    if (HIGH_FIRST != 0) begin
      for (int i = 0; i < 8; i++)
        if (r_pend[i]) w_idx = 3'(i);
    end else begin
      for (int i = 7; i >= 0; i--)
        if (r_pend[i]) w_idx = 3'(i);
    end
  end

  assign w_onehot = (r_pend != 8'd0) && ((r_pend & (r_pend - 8'd1)) == 8'd0);
  assign w_drain  = (r_state == S_DRAIN);

  assign V    = w_drain;
  assign busy = w_drain;
  assign A    = w_drain ? w_idx : 3'd0;
  assign last = w_drain & w_onehot;
  assign Z    = r_z;

`ifdef PENDING_COUNT_EN
  assign cnt = w_drain ? 4'($countones(r_pend)) : 4'd0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pend  <= 8'd0;
      r_z     <= 1'b0;
    end else begin
      r_z <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (load && E) begin
            if (D != 8'd0) begin
              r_pend  <= D;
              r_state <= S_DRAIN;
            end else begin
              r_z <= 1'b1;
            end
          end
        end
        S_DRAIN: begin
          if (ready) begin
            r_pend[w_idx] <= 1'b0;
            if (w_onehot) r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prio_encoder_8to3_seq.sv
// Bench for prio_encoder_8to3_seq: both scan orders side by side against a queue-based reference.
// Define PENDING_COUNT_EN to also check cnt.
module tb_prio_encoder_8to3_seq;

  logic       clk = 1'b0;
  logic       rst, E, load, ready;
  logic [7:0] D;
  logic [2:0] a_h, a_l;
  logic       v_h, v_l, last_h, last_l, busy_h, busy_l, z_h, z_l;
`ifdef PENDING_COUNT_EN
  logic [3:0] cnt_h, cnt_l;
`endif

  always #5 clk = ~clk;

  prio_encoder_8to3_seq #(.HIGH_FIRST(1)) dut_h (
    .clk(clk), .rst(rst), .E(E), .D(D), .load(load), .ready(ready),
    .A(a_h), .V(v_h), .last(last_h), .busy(busy_h),
`ifdef PENDING_COUNT_EN
    .cnt(cnt_h),
`endif
    .Z(z_h));

  prio_encoder_8to3_seq #(.HIGH_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .E(E), .D(D), .load(load), .ready(ready),
    .A(a_l), .V(v_l), .last(last_l), .busy(busy_l),
`ifdef PENDING_COUNT_EN
    .cnt(cnt_l),
`endif
    .Z(z_l));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: the pending indices in emission order, one queue per scan order.
  int qh[$];
  int ql[$];
  bit mz = 1'b0;

  logic [2:0] s_ah, s_al;
  logic       s_v, s_lh, s_ll, s_bh, s_zh, s_zl;
`ifdef PENDING_COUNT_EN
  logic [3:0] s_ch;
`endif

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit vv;
    vv = (qh.size() != 0);
    chk("model V_h",    {7'd0, v_h},    {7'd0, vv});
    chk("model V_l",    {7'd0, v_l},    {7'd0, vv});
    chk("model busy_h", {7'd0, busy_h}, {7'd0, vv});
    chk("model busy_l", {7'd0, busy_l}, {7'd0, vv});
    chk("model A_h",    {5'd0, a_h},    vv ? 8'(qh[0]) : 8'd0);
    chk("model A_l",    {5'd0, a_l},    vv ? 8'(ql[0]) : 8'd0);
    chk("model last_h", {7'd0, last_h}, {7'd0, qh.size() == 1});
    chk("model last_l", {7'd0, last_l}, {7'd0, ql.size() == 1});
    chk("model Z_h",    {7'd0, z_h},    {7'd0, mz});
    chk("model Z_l",    {7'd0, z_l},    {7'd0, mz});
`ifdef PENDING_COUNT_EN
    chk("model cnt_h",  {4'd0, cnt_h},  8'(qh.size()));
    chk("model cnt_l",  {4'd0, cnt_l},  8'(ql.size()));
`endif
  endtask

  task automatic model_update();
    bit zn;
    zn = 1'b0;
    if (qh.size() == 0) begin
      if (load && E) begin
        if (D != 8'd0) begin
          for (int i = 7; i >= 0; i--) if (D[i]) qh.push_back(i);
          for (int i = 0; i < 8; i++)  if (D[i]) ql.push_back(i);
        end else begin
          zn = 1'b1;
        end
      end
    end else if (ready) begin
      void'(qh.pop_front());
      void'(ql.pop_front());
    end
    mz = zn;
  endtask

  // One clock: drive inputs, sample and check mid-cycle, advance model with the edge.
  task automatic cyc(input logic l, input logic e, input logic [7:0] d, input logic r);
    load = l; E = e; D = d; ready = r;
    @(negedge clk);
    s_ah = a_h; s_al = a_l; s_v = v_h; s_lh = last_h; s_ll = last_l;
    s_bh = busy_h; s_zh = z_h; s_zl = z_l;
`ifdef PENDING_COUNT_EN
    s_ch = cnt_h;
`endif
    check_model();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       e;
    logic       z;
    int         k;
    logic [2:0] hi;
    logic [2:0] lo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    bit done;
    logic [2:0] exp_seq[3];

    vecs[0] = '{8'hA4, 1'b1, 1'b0, 3, 3'd7, 3'd2};
    vecs[1] = '{8'h00, 1'b1, 1'b1, 0, 3'd0, 3'd0};
    vecs[2] = '{8'h10, 1'b0, 1'b0, 0, 3'd0, 3'd0};
    vecs[3] = '{8'hFF, 1'b1, 1'b0, 8, 3'd7, 3'd0};
    vecs[4] = '{8'h01, 1'b1, 1'b0, 1, 3'd0, 3'd0};
    vecs[5] = '{8'h80, 1'b1, 1'b0, 1, 3'd7, 3'd7};
    vecs[6] = '{8'h81, 1'b1, 1'b0, 2, 3'd7, 3'd0};
    vecs[7] = '{8'h3C, 1'b1, 1'b0, 4, 3'd5, 3'd2};

    rst = 1'b1; E = 1'b0; load = 1'b0; ready = 1'b0; D = 8'd0;
    #12;
    chk("reset V",    {7'd0, v_h | v_l},       8'd0);
    chk("reset A",    {2'd0, a_h, a_l},        8'd0);
    chk("reset busy", {7'd0, busy_h | busy_l}, 8'd0);
    chk("reset Z",    {7'd0, z_h | z_l},       8'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven: first index after load, Z, and valid-cycle count.
    foreach (vecs[j]) begin
      cyc(1'b1, vecs[j].e, vecs[j].d, 1'b0);
      cyc(1'b0, 1'b0, 8'd0, 1'b0);
      chk("vec V",    {7'd0, s_v},  {7'd0, vecs[j].k != 0});
      chk("vec A_h",  {5'd0, s_ah}, {5'd0, vecs[j].hi});
      chk("vec A_l",  {5'd0, s_al}, {5'd0, vecs[j].lo});
      chk("vec Z",    {6'd0, s_zh, s_zl}, {6'd0, vecs[j].z, vecs[j].z});
      n = 0; done = 1'b0;
      for (int c = 0; c < 12 && !done; c++) begin
        cyc(1'b0, 1'b0, 8'd0, 1'b1);
        if (!s_v) done = 1'b1; else n++;
      end
      chk("vec drain done", {7'd0, done}, 8'd1);
      chk("vec count", 8'(n), 8'(vecs[j].k));
    end

    // A4 explicit sequence with ready held high.
    exp_seq[0] = 3'd7; exp_seq[1] = 3'd5; exp_seq[2] = 3'd2;
    cyc(1'b1, 1'b1, 8'hA4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 8'd0, 1'b1);
      chk("a4 A_h", {5'd0, s_ah}, {5'd0, exp_seq[i]});
      chk("a4 A_l", {5'd0, s_al}, {5'd0, exp_seq[2-i]});
      chk("a4 last", {6'd0, s_lh, s_ll}, (i == 2) ? 8'd3 : 8'd0);
`ifdef PENDING_COUNT_EN
      chk("a4 cnt", {4'd0, s_ch}, 8'(3 - i));
`endif
    end
    cyc(1'b0, 1'b0, 8'd0, 1'b1);
    chk("a4 busy after", {7'd0, s_bh}, 8'd0);
`ifdef PENDING_COUNT_EN
    chk("a4 cnt after", {4'd0, s_ch}, 8'd0);
`endif

    // FF with 3 cycles of backpressure.
    cyc(1'b1, 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 8'd0, 1'b0);
      chk("bp hold A_h", {5'd0, s_ah}, 8'd7);
      chk("bp hold V",   {7'd0, s_v},  8'd1);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b0, 8'd0, 1'b1);
      chk("bp A_h", {5'd0, s_ah}, 8'(7 - i));
      chk("bp A_l", {5'd0, s_al}, 8'(i));
    end
    cyc(1'b0, 1'b0, 8'd0, 1'b1);
    chk("bp idle", {7'd0, s_v}, 8'd0);

    // Zero load pulses Z once; disabled load does nothing.
    cyc(1'b1, 1'b1, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 1'b0);
    chk("z pulse", {6'd0, s_zh, s_zl, 1'b0} >> 1, 8'd3);
    chk("z V", {7'd0, s_v}, 8'd0);
    cyc(1'b1, 1'b0, 8'h10, 1'b0);
    chk("z once", {6'd0, s_zh, s_zl}, 8'd0);
    cyc(1'b0, 1'b0, 8'd0, 1'b0);
    chk("E=0 V", {7'd0, s_v}, 8'd0);
    chk("E=0 Z", {6'd0, s_zh, s_zl}, 8'd0);

    // Load during drain is ignored.
    cyc(1'b1, 1'b1, 8'h81, 1'b0);
    cyc(1'b1, 1'b1, 8'h0F, 1'b1);
    chk("mid A_h first", {5'd0, s_ah}, 8'd7);
    cyc(1'b1, 1'b1, 8'h0F, 1'b1);
    chk("mid A_h second", {5'd0, s_ah}, 8'd0);
    chk("mid A_l second", {5'd0, s_al}, 8'd7);
    chk("mid last", {6'd0, s_lh, s_ll}, 8'd3);
    cyc(1'b0, 1'b0, 8'd0, 1'b1);
    chk("mid idle", {7'd0, s_v}, 8'd0);

    // Asynchronous reset mid-drain.
    cyc(1'b1, 1'b1, 8'hFF, 1'b0);
    cyc(1'b0, 1'b0, 8'd0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst V",    {6'd0, v_h, v_l},       8'd0);
    chk("arst A",    {2'd0, a_h, a_l},       8'd0);
    chk("arst busy", {6'd0, busy_h, busy_l}, 8'd0);
    chk("arst last", {6'd0, last_h, last_l}, 8'd0);
    qh.delete(); ql.delete(); mz = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    cyc(1'b1, 1'b1, 8'h02, 1'b1);
    cyc(1'b0, 1'b0, 8'd0, 1'b1);
    chk("post-rst A", {2'd0, s_ah, s_al}, {2'd0, 3'd1, 3'd1});
    chk("post-rst last", {6'd0, s_lh, s_ll}, 8'd3);

    // Random traffic against the reference.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
          ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom),
          1'($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
